vram_arb: RTL
=============

VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter ADDR_W, 16, video RAM address width.
REQ-002 Parameter DATA_W, 8, video RAM data width.
REQ-003 Parameter LINE_WORDS, 80, words fetched per scanline fetch; range 1..2^ADDR_W-1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 fetchStart  input  1  one-cycle pulse requesting a scanline fetch.
REQ-007 fetchBase  input  ADDR_W  first fetch address, sampled when fetchStart accepted.
REQ-008 hostReq  input  1  host access request, held high until hostAck.
REQ-009 hostWe  input  1  1 = write, 0 = read; sampled with hostReq.
REQ-010 hostAddr  input  ADDR_W  host address.
REQ-011 hostWdata  input  DATA_W  host write data.
REQ-012 ovrClr  input  1  clears overrun flag.
REQ-013 memRdata  input  DATA_W  RAM read data, valid one cycle after read issue.
REQ-014 memEn, memWe  output  1 each  RAM enable, write enable.
REQ-015 memAddr, memWdata  output  ADDR_W, DATA_W  RAM address, write data.
REQ-016 fetchValid  output  1  fetchData valid this cycle.
REQ-017 fetchData  output  DATA_W  fetched word.
REQ-018 fetchDone  output  1  one-cycle pulse coincident with last fetchValid.
REQ-019 hostAck  output  1  one-cycle completion pulse.
REQ-020 hostRdata  output  DATA_W  read data, valid while hostAck high.
REQ-021 overrun  output  1  sticky: fetchStart dropped.
REQ-022 busy  output  1  high in any state other than IDLE or while a fetch is pending.

Function
REQ-023 FSM states SHALL be IDLE, FETCH, HOST, ACK.
REQ-024 IDLE: pending fetch or fetchStart -> FETCH; else hostReq -> HOST; else stay; fetch wins on simultaneous requests.
REQ-025 FETCH: one read per cycle, memEn=1, memWe=0, memAddr=base+idx, idx 0..LINE_WORDS-1, address wraps modulo 2^ADDR_W; after idx=LINE_WORDS-1 -> IDLE.
REQ-026 Fetch latency: fetchStart at cycle N (IDLE) -> first issue N+1, first fetchValid N+2, last fetchValid and fetchDone N+1+LINE_WORDS.
REQ-027 fetchValid/fetchData SHALL be registered from memRdata one cycle after each issue; no gaps within a fetch.
REQ-028 HOST: single cycle, memEn=1, memWe=hostWe, memAddr=hostAddr, memWdata=hostWdata -> ACK.
REQ-029 ACK: hostAck=1, hostRdata=memRdata (reads; don't-care for writes) -> IDLE; hostReq sampled high in the following IDLE is a new request.
REQ-030 Host latency: hostReq sampled in IDLE at N -> issue N+1, hostAck N+2, next possible issue N+4.
REQ-031 fetchStart during HOST or ACK SHALL latch fetchBase as pending; served from the next IDLE ahead of hostReq.
REQ-032 fetchStart during FETCH (except on its last issue cycle), or with a fetch already pending, SHALL be dropped and set overrun.
REQ-033 fetchStart on the last FETCH issue cycle SHALL be latched pending and served with one IDLE cycle between fetches.
REQ-034 overrun cleared by ovrClr when no new overrun that cycle; set wins over clear.
REQ-035 memEn=0 and memWe=0 in IDLE and ACK.

Reset
REQ-036 rst SHALL asynchronously force IDLE, clear pending, idx, overrun, and drive memEn, memWe, fetchValid, fetchDone, hostAck, busy to 0, memAddr, memWdata, fetchData, hostRdata to 0.
REQ-037 Reset mid-fetch or mid-host SHALL abort without ack or further fetchValid; the aborted host request is re-served only if hostReq is still high after release.

Verification
REQ-038 LINE_WORDS=4, fetchStart base 0x00FE at N -> memAddr 0x00FE,0x00FF,0x0100,0x0101 at N+1..N+4; fetchValid N+2..N+5; fetchDone at N+5.
REQ-039 Host write 0x1234<=0xA5 then read 0x1234 -> hostAck at N+2 each; read hostRdata=0xA5.
REQ-040 fetchStart and hostReq same IDLE cycle -> fetch runs first; host issue one cycle after fetch returns to IDLE.
REQ-041 fetchStart at fetch issue idx 1 -> overrun=1, fetch unaffected; ovrClr -> overrun=0 next cycle.
REQ-042 base 0xFFFF, LINE_WORDS=3 -> addresses 0xFFFF,0x0000,0x0001.
REQ-043 rst asserted mid-fetch -> outputs 0 immediately, no fetchDone; normal fetch after release.

Source files
------------

// File: rtl/vram_arb.sv
// Video RAM arbiter: interleaves scanline burst fetches with single host accesses
// on one RAM port. Fetches take priority and can queue one pending request.
module vram_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetchStart,
    input  logic [ADDR_W-1:0] fetchBase,
    input  logic              hostReq,
    input  logic              hostWe,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWdata,
    input  logic              ovrClr,
    input  logic [DATA_W-1:0] memRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic              fetchValid,
    output logic [DATA_W-1:0] fetchData,
    output logic              fetchDone,
    output logic              hostAck,
    output logic [DATA_W-1:0] hostRdata,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOST  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_WORDS - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] base_r;
    logic              pend_r;
    logic              pend_nxt_s;
    logic [ADDR_W-1:0] pend_base_r;
    logic [ADDR_W-1:0] pend_base_nxt_s;
    logic [ADDR_W-1:0] go_base_s;
    logic              go_fetch_s;
    logic              go_host_s;
    logic              can_latch_s;
    logic              accepted_s;
    logic              ovr_set_s;

    // Next-state, pending-fetch queue and overrun detection
    always_comb begin
        state_nxt_s     = state_r;
        pend_nxt_s      = pend_r;
        pend_base_nxt_s = pend_base_r;
        go_base_s       = pend_r ? pend_base_r : fetchBase;
        go_fetch_s      = 1'b0;
        go_host_s       = 1'b0;
        can_latch_s     = 1'b0;
        accepted_s      = 1'b0;
        ovr_set_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_r || fetchStart) begin
                    state_nxt_s = FETCH;
                    go_fetch_s  = 1'b1;
                    pend_nxt_s  = 1'b0;
                    accepted_s  = !pend_r;
                end else if (hostReq) begin
                    state_nxt_s = HOST;
                    go_host_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = IDLE;
                    can_latch_s = 1'b1;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOST: begin
                state_nxt_s = ACK;
                can_latch_s = 1'b1;
            end
            ACK: begin
                state_nxt_s = IDLE;
                can_latch_s = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        // A start that is neither accepted nor queueable is lost
        if (fetchStart && !accepted_s) begin
            if (can_latch_s && !pend_r) begin
                pend_nxt_s      = 1'b1;
                pend_base_nxt_s = fetchBase;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else begin
            ovr_set_s = 1'b0;
        end
    end

    // State register and registered RAM/client outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            base_r      <= '0;
            pend_r      <= 1'b0;
            pend_base_r <= '0;
            memEn       <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            fetchValid  <= 1'b0;
            fetchData   <= '0;
            fetchDone   <= 1'b0;
            hostAck     <= 1'b0;
            hostRdata   <= '0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pend_r      <= pend_nxt_s;
            pend_base_r <= pend_base_nxt_s;
            overrun     <= ovr_set_s | (overrun & ~ovrClr);
            busy        <= (state_nxt_s != IDLE) | pend_nxt_s;
            fetchValid  <= (state_r == FETCH);
            fetchDone   <= (state_r == FETCH) && (idx_r == LAST_IDX);
            hostAck     <= (state_r == HOST);
            if (state_r == FETCH) begin
                fetchData <= memRdata;
            end
            if (state_r == HOST) begin
                hostRdata <= memRdata;
            end
            if (go_fetch_s) begin
                memEn   <= 1'b1;
                memWe   <= 1'b0;
                memAddr <= go_base_s;
                base_r  <= go_base_s;
                idx_r   <= '0;
            end else if (go_host_s) begin
                memEn    <= 1'b1;
                memWe    <= hostWe;
                memAddr  <= hostAddr;
                memWdata <= hostWdata;
            end else if ((state_r == FETCH) && (idx_r != LAST_IDX)) begin
                memEn   <= 1'b1;
                memWe   <= 1'b0;
                idx_r   <= idx_r + ADDR_W'(1);
                memAddr <= base_r + idx_r + ADDR_W'(1);
            end else begin
                memEn <= 1'b0;
                memWe <= 1'b0;
            end
        end
    end

endmodule
